// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared select encoding and default bus widths for the imem/dmem bus arbiter
package mem_arb_pkg;
  localparam int MEM_ADDR_W_DEF = 64;
  localparam int MEM_STRB_W_DEF = 8;
  localparam int MEM_DATA_W_DEF = 64;
  localparam int MAX_STARVE_DEF = 4;
  typedef enum logic {
    SEL_IMEM = 1'b0,
    SEL_DMEM = 1'b1
  } mem_sel_e;
endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: saturating count of dmem grants taken while imem waits
// Ports: g_clk/g_resetn clock and async active-low reset; inc counts one
// starved grant; clr restarts the count; at_max flags the count at MAX_STARVE.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX_STARVE = MAX_STARVE_DEF
) (
  input  logic g_clk,
  input  logic g_resetn,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam int W = $clog2(MAX_STARVE + 1);
  logic [W-1:0] cnt;
  assign at_max = cnt == W'(MAX_STARVE);
  always_ff @(posedge g_clk or negedge g_resetn)
    if (!g_resetn) cnt <= '0;
    else cnt <= clr ? '0 : (inc && !at_max) ? cnt + W'(1) : cnt;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one req/gnt memory bus between imem and dmem requesters
// Ports: g_clk/g_resetn clock and async active-low reset; imem_*/dmem_* are the
// two requester ports (req/addr/wen/strb/wdata in, gnt/err/rdata out); bus_* is
// the shared bus (req and muxed fields out, gnt/err/rdata in).
// dmem has fixed priority, except imem wins once dmem has been granted
// MAX_STARVE times in a row while imem waited. A stalled request keeps its owner.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_ADDR_W = MEM_ADDR_W_DEF,
  parameter int MEM_STRB_W = MEM_STRB_W_DEF,
  parameter int MEM_DATA_W = MEM_DATA_W_DEF,
  parameter int MAX_STARVE = MAX_STARVE_DEF
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  imem_req,
  input  logic [MEM_ADDR_W-1:0] imem_addr,
  input  logic                  imem_wen,
  input  logic [MEM_STRB_W-1:0] imem_strb,
  input  logic [MEM_DATA_W-1:0] imem_wdata,
  output logic                  imem_gnt,
  output logic                  imem_err,
  output logic [MEM_DATA_W-1:0] imem_rdata,
  input  logic                  dmem_req,
  input  logic [MEM_ADDR_W-1:0] dmem_addr,
  input  logic                  dmem_wen,
  input  logic [MEM_STRB_W-1:0] dmem_strb,
  input  logic [MEM_DATA_W-1:0] dmem_wdata,
  output logic                  dmem_gnt,
  output logic                  dmem_err,
  output logic [MEM_DATA_W-1:0] dmem_rdata,
  output logic                  bus_req,
  output logic [MEM_ADDR_W-1:0] bus_addr,
  output logic                  bus_wen,
  output logic [MEM_STRB_W-1:0] bus_strb,
  output logic [MEM_DATA_W-1:0] bus_wdata,
  input  logic                  bus_gnt,
  input  logic                  bus_err,
  input  logic [MEM_DATA_W-1:0] bus_rdata
);
  logic sel, lock, lock_sel, rsp_valid, rsp_sel, at_max, is_i;
  // In reset the mux parks on dmem and every handshake output is held low.
  always_comb begin
    sel = !g_resetn ? SEL_DMEM :
          lock ? lock_sel :
          (imem_req && (!dmem_req || at_max)) ? SEL_IMEM : SEL_DMEM;
    is_i = sel == SEL_IMEM;
    bus_req = g_resetn && (is_i ? imem_req : dmem_req);
    bus_addr = is_i ? imem_addr : dmem_addr;
    bus_wen = is_i ? imem_wen : dmem_wen;
    bus_strb = is_i ? imem_strb : dmem_strb;
    bus_wdata = is_i ? imem_wdata : dmem_wdata;
    imem_gnt = bus_gnt && bus_req && is_i;
    dmem_gnt = bus_gnt && bus_req && !is_i;
    imem_err = g_resetn && bus_err && rsp_valid && rsp_sel == SEL_IMEM;
    dmem_err = g_resetn && bus_err && rsp_valid && rsp_sel == SEL_DMEM;
  end
  assign imem_rdata = bus_rdata;
  assign dmem_rdata = bus_rdata;
  // lock_sel may track sel every cycle: it is only consulted while lock holds,
  // and lock is only raised in a cycle whose sel is the owner being stalled.
  // A locked requester dropping req drops bus_req too, which releases the lock.
  always_ff @(posedge g_clk or negedge g_resetn)
    if (!g_resetn) begin
      lock      <= 1'b0;
      lock_sel  <= SEL_IMEM;
      rsp_valid <= 1'b0;
      rsp_sel   <= SEL_IMEM;
    end else begin
      lock      <= bus_req && !bus_gnt;
      lock_sel  <= sel;
      rsp_valid <= bus_req && bus_gnt;
      rsp_sel   <= sel;
    end
  mem_arb_starve_ctr #(.MAX_STARVE(MAX_STARVE)) u_starve (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .inc      (dmem_gnt && imem_req),
    .clr      (imem_gnt || !imem_req),
    .at_max   (at_max)
  );
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        imem_req, imem_wen, dmem_req, dmem_wen;
  logic [63:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata;
  logic [7:0]  imem_strb, dmem_strb;
  logic        imem_gnt, imem_err, dmem_gnt, dmem_err;
  logic [63:0] imem_rdata, dmem_rdata;
  logic        bus_req, bus_wen, bus_gnt, bus_err;
  logic [63:0] bus_addr, bus_wdata, bus_rdata;
  logic [7:0]  bus_strb;
  int checks = 0;
  int errors = 0;
  always #5 g_clk = ~g_clk;
  mem_bus_arbiter dut (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_wen   (imem_wen),
    .imem_strb  (imem_strb),
    .imem_wdata (imem_wdata),
    .imem_gnt   (imem_gnt),
    .imem_err   (imem_err),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_addr  (dmem_addr),
    .dmem_wen   (dmem_wen),
    .dmem_strb  (dmem_strb),
    .dmem_wdata (dmem_wdata),
    .dmem_gnt   (dmem_gnt),
    .dmem_err   (dmem_err),
    .dmem_rdata (dmem_rdata),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_wen    (bus_wen),
    .bus_strb   (bus_strb),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_err    (bus_err),
    .bus_rdata  (bus_rdata)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic idle();
    imem_req = 0; dmem_req = 0; imem_wen = 0; dmem_wen = 0;
    imem_strb = 0; dmem_strb = 0; imem_wdata = 0; dmem_wdata = 0;
    bus_gnt = 0; bus_err = 0; bus_rdata = 0;
  endtask
  task automatic cyc();
    @(negedge g_clk);
  endtask
  initial begin
    logic [9:0] order;
    order = 10'b10_0001_0000;
    g_resetn = 0;
    idle();
    imem_addr = 64'h66; dmem_addr = 64'h55;
    imem_req = 1; bus_gnt = 1; bus_err = 1;
    #1;
    check("rst_bus_req", bus_req, 0);
    check("rst_imem_gnt", imem_gnt, 0);
    check("rst_dmem_gnt", dmem_gnt, 0);
    check("rst_imem_err", imem_err, 0);
    check("rst_dmem_err", dmem_err, 0);
    check("rst_addr_dmem", bus_addr, 64'h55);
    cyc(); cyc();
    g_resetn = 1; idle();
    cyc();
    imem_req = 1; imem_addr = 64'h80; bus_gnt = 1; #1;
    check("rd_bus_addr", bus_addr, 64'h80);
    check("rd_bus_req", bus_req, 1);
    check("rd_imem_gnt", imem_gnt, 1);
    check("rd_dmem_gnt", dmem_gnt, 0);
    cyc();
    idle(); bus_rdata = 64'hDEAD; #1;
    check("rd_imem_rdata", imem_rdata, 64'hDEAD);
    check("rd_imem_err", imem_err, 0);
    check("rd_dmem_err", dmem_err, 0);
    cyc();
    imem_req = 1; dmem_req = 1; imem_addr = 64'h100; dmem_addr = 64'h200; bus_gnt = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("cont_imem_gnt%0d", i), imem_gnt, order[i]);
      check($sformatf("cont_dmem_gnt%0d", i), dmem_gnt, !order[i]);
      check($sformatf("cont_addr%0d", i), bus_addr, order[i] ? 64'h100 : 64'h200);
      cyc();
    end
    idle(); cyc();
    imem_req = 1; #1;
    check("lk_i_bus_req", bus_req, 1);
    cyc();
    dmem_req = 1; #1;
    check("lk_i_addr", bus_addr, 64'h100);
    check("lk_i_dmem_gnt", dmem_gnt, 0);
    cyc();
    bus_gnt = 1; #1;
    check("lk_i_imem_gnt", imem_gnt, 1);
    check("lk_i_dmem_gnt2", dmem_gnt, 0);
    cyc();
    idle(); cyc();
    dmem_req = 1; dmem_wdata = 64'hAA; #1;
    check("st_addr1", bus_addr, 64'h200);
    check("st_dmem_gnt1", dmem_gnt, 0);
    cyc();
    imem_req = 1; #1;
    check("st_addr2", bus_addr, 64'h200);
    check("st_wdata2", bus_wdata, 64'hAA);
    check("st_imem_gnt2", imem_gnt, 0);
    cyc(); #1;
    check("st_addr3", bus_addr, 64'h200);
    check("st_dmem_gnt3", dmem_gnt, 0);
    cyc();
    bus_gnt = 1; #1;
    check("st_dmem_gnt4", dmem_gnt, 1);
    check("st_imem_gnt4", imem_gnt, 0);
    cyc();
    dmem_req = 0; #1;
    check("st_imem_gnt5", imem_gnt, 1);
    check("st_addr5", bus_addr, 64'h100);
    cyc();
    idle(); imem_req = 1; cyc();
    imem_req = 0; dmem_req = 1; #1;
    check("drop_bus_req", bus_req, 0);
    check("drop_dmem_gnt", dmem_gnt, 0);
    cyc();
    bus_gnt = 1; #1;
    check("drop_dmem_gnt2", dmem_gnt, 1);
    cyc();
    idle(); imem_req = 1; bus_gnt = 1; #1;
    check("er_imem_gnt", imem_gnt, 1);
    cyc();
    imem_req = 0; dmem_req = 1; bus_err = 1; #1;
    check("er_dmem_gnt", dmem_gnt, 1);
    check("er_imem_err", imem_err, 1);
    check("er_dmem_err1", dmem_err, 0);
    cyc();
    idle(); #1;
    check("er_dmem_err0", dmem_err, 0);
    check("er_imem_err0", imem_err, 0);
    bus_err = 1; #1;
    check("er_dmem_err", dmem_err, 1);
    check("er_imem_err2", imem_err, 0);
    cyc();
    idle(); imem_req = 1; cyc();
    dmem_req = 1; bus_gnt = 1; bus_err = 1; g_resetn = 0; #1;
    check("rs_bus_req", bus_req, 0);
    check("rs_imem_gnt", imem_gnt, 0);
    check("rs_dmem_gnt", dmem_gnt, 0);
    check("rs_imem_err", imem_err, 0);
    check("rs_dmem_err", dmem_err, 0);
    cyc();
    g_resetn = 1; imem_req = 0; bus_err = 0; #1;
    check("rs_dmem_first", dmem_gnt, 1);
    cyc();
    g_resetn = 0; #1;
    g_resetn = 1; idle(); bus_err = 1; #1;
    check("rs_rsp_dropped", dmem_err, 0);
    cyc();
    idle(); dmem_req = 1; dmem_wen = 1; dmem_strb = 8'h0F;
    dmem_wdata = 64'h1122334455667788; bus_gnt = 1; #1;
    check("wr_dmem_gnt", dmem_gnt, 1);
    check("wr_bus_wen", bus_wen, 1);
    check("wr_bus_strb", bus_strb, 8'h0F);
    check("wr_bus_wdata", bus_wdata, 64'h1122334455667788);
    cyc();
    idle(); cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
